// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It resolves
// load-use hazards, EX-stage mispredictions and multi-cycle memory accesses
// guarded by a timeout watchdog. It also keeps saturating stall and flush
// performance counters.
// Enable/flush/bubble outputs are combinational from the state and the
// current inputs. State, halt flag and counters are registered.
// WAIT_MAX legal range is 1..255.

module pipe_hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_is_load,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_memwb_bubble,
  output logic             o_halt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Last wait-counter value tolerated before the watchdog fires: a WAIT cycle
  // without ack that starts at this value is the WAIT_MAX-th such cycle.
  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [7:0]       WAIT_SAT  = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic             halt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             lu_s;
  logic             mb_s;

  logic             pc_en_s;
  logic             ifid_en_s;
  logic             idex_en_s;
  logic             exmem_en_s;
  logic             ifid_flush_s;
  logic             idex_flush_s;
  logic             memwb_bubble_s;
  logic             flush_evt_s;
  logic             stall_evt_s;

  // Hazard conditions: load-use against the EX load, and a memory access still in flight.
  always_comb begin
    rs1_hit_s = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    rs2_hit_s = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
    lu_s      = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) & (rs1_hit_s | rs2_hit_s);
    mb_s      = i_mem_req & ~i_mem_ack;
  end

  // State register: RUN / WAIT / HALT.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. An unreachable encoding falls into HALT so the core freezes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mb_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (i_mem_ack) begin
          state_nxt_s = ST_RUN;
        end else if (wait_cnt_r >= WAIT_LAST) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // Output decode. A freeze (HALT or busy memory) beats a mispredict, which beats load-use.
  always_comb begin
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    idex_en_s      = 1'b1;
    exmem_en_s     = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    memwb_bubble_s = 1'b0;
    flush_evt_s    = 1'b0;
    case (state_r)
      ST_RUN, ST_WAIT: begin
        if (mb_s) begin
          // EX is frozen and keeps its inputs, so mispredict/lu are acted on later.
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          idex_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
        end else if (i_ex_mispred) begin
          ifid_flush_s   = 1'b1;
          idex_flush_s   = 1'b1;
          flush_evt_s    = 1'b1;
        end else if (lu_s) begin
          // Hold PC and IF/ID one cycle and send a bubble into EX.
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          idex_flush_s   = 1'b1;
        end else begin
          pc_en_s        = 1'b1;
        end
      end
      default: begin
        pc_en_s        = 1'b0;
        ifid_en_s      = 1'b0;
        idex_en_s      = 1'b0;
        exmem_en_s     = 1'b0;
        memwb_bubble_s = 1'b1;
      end
    endcase
  end

  // Stall cycles are counted only while the core is still alive.
  assign stall_evt_s = ~pc_en_s & (state_r != ST_HALT);

  // Wait counter: cleared on entry to WAIT and advanced on each un-acked WAIT cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_RUN) && (state_nxt_s == ST_WAIT)) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && !i_mem_ack && (wait_cnt_r != WAIT_SAT)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Halt flag: set together with the entry into HALT, held until reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halt_r <= 1'b0;
    end else begin
      halt_r <= (state_nxt_s == ST_HALT);
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_r <= '0;
    end else if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Saturating mispredict-flush counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      flush_cnt_r <= '0;
    end else if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
      flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign o_pc_en        = pc_en_s;
  assign o_ifid_en      = ifid_en_s;
  assign o_idex_en      = idex_en_s;
  assign o_exmem_en     = exmem_en_s;
  assign o_ifid_flush   = ifid_flush_s;
  assign o_idex_flush   = idex_flush_s;
  assign o_memwb_bubble = memwb_bubble_s;
  assign o_halt         = halt_r;
  assign o_stall_cnt    = stall_cnt_r;
  assign o_flush_cnt    = flush_cnt_r;
  assign o_state        = state_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers, and inserts a bubble into the MEM/WB register. It resolves three conditions:

- load-use hazards;
- EX-stage branch mispredictions;
- multi-cycle data-memory/peripheral accesses with a request/acknowledge handshake and a timeout watchdog.

It also keeps saturating performance counters for stall cycles and flush events.

## Interface

Parameters:

- CNT_W, 32: width of the stall and flush performance counters.
- WAIT_MAX, 16: maximum number of WAIT cycles before a timeout is declared. Legal range is 1..255.

Ports:

- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  source registers of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  in  1 each  the ID instruction reads rs1/rs2.
- i_ex_rd_addr  in  5  destination register of the instruction in EX.
- i_ex_rd_wren  in  1  the EX instruction writes rd.
- i_ex_is_load  in  1  the EX instruction is a load.
- i_ex_mispred  in  1  a branch/jump resolved in EX was mispredicted.
- i_mem_req  in  1  the MEM stage instruction needs a multi-cycle access.
- i_mem_ack  in  1  the access completes this cycle.
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en  out  1 each  register enables (1 = advance).
- o_ifid_flush, o_idex_flush  out  1 each  synchronous clear to a bubble at the next edge.
- o_memwb_bubble  out  1  forces MEM/WB insn_vld and rd_wren to 0 at the next edge.
- o_halt  out  1  watchdog timeout occurred; the core is frozen.
- o_stall_cnt  out  CNT_W  number of cycles with any stall.
- o_flush_cnt  out  CNT_W  number of mispredict flush events.
- o_state  out  2  current state: RUN=0, WAIT=1, HALT=2.

## Operation

Load-use condition (lu):

- i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 0) & ((i_id_rs1_used & rs1 == rd) | (i_id_rs2_used & rs2 == rd)).

Memory-busy condition (mb):

- i_mem_req & ~i_mem_ack.

Output decode:

- **HALT, or mb asserted in RUN or WAIT:**
  - All enables are 0 and both flushes are 0.
  - o_memwb_bubble = 1.
  - The mispredict and load-use checks are suppressed, because EX is frozen and holds its inputs.
- **Otherwise, i_ex_mispred = 1:**
  - All enables are 1.
  - o_ifid_flush = 1 and o_idex_flush = 1.
  - lu is ignored.
- **Otherwise, lu = 1:**
  - o_pc_en = 0 and o_ifid_en = 0.
  - o_idex_en = 1 with o_idex_flush = 1, which inserts a bubble.
  - o_exmem_en = 1.
- **Otherwise:** all enables are 1, all flushes are 0, and o_memwb_bubble = 0.

State machine:

- RUN -> WAIT when mb = 1. A zero-wait access (req and ack in the same cycle) stays in RUN with no stall.
- WAIT -> RUN in the cycle i_mem_ack = 1. The pipeline advances in that cycle, and mispredict and lu are evaluated normally.
- WAIT -> HALT when the wait counter reaches WAIT_MAX while ack = 0.
- HALT persists until reset. o_halt = 1 and every enable stays 0.

Wait counter:

- Width is 8 bits.
- Cleared on entry to WAIT.
- Increments each WAIT cycle in which ack = 0.

Performance counters:

- o_stall_cnt increments on every cycle where o_pc_en = 0 and the state is not HALT.
- o_flush_cnt increments on every mispredict flush.
- Both counters saturate at 2^CNT_W-1.

## Timing

- Reset values: o_state = RUN, wait counter = 0, o_stall_cnt = 0, o_flush_cnt = 0, o_halt = 0.
- After reset the decode outputs follow the RUN decode of the current inputs. With idle inputs all enables are 1 and all flushes/bubbles are 0.
- Enable, flush and bubble outputs are combinational from the state and the current inputs, with zero-cycle latency.
- o_state, o_halt and both counters are registered and update at the edge after the qualifying cycle.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM, so lu deasserts.
- A mispredict costs 2 bubbles, those in IF/ID and ID/EX.
- A WAIT of N cycles costs N stall cycles. If the ack arrives in the Nth WAIT cycle, the pipeline advances on that cycle's edge.
- Reset asserted mid-WAIT or in HALT returns to RUN asynchronously and clears the counters.
- mb together with i_ex_mispred: mb wins. The mispredict is acted on in the cycle the ack arrives.

## Test plan

- **Load-use:** ex load with rd=5, ID rs1=5 used -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0->1. The same case with rd=0 produces no stall.
- **Mispredict:** pulse i_ex_mispred for 1 cycle with lu also true -> ifid_flush=idex_flush=1, all enables 1; flush_cnt=1, stall_cnt=0.
- **Multi-cycle access:** req held and ack raised on the 4th cycle -> 3 cycles with all enables 0 and memwb_bubble=1, o_state=1, then advance; stall_cnt=3, state returns to RUN.
- **Simultaneous events:** req without ack plus mispredict -> no flush while waiting; flush asserted in the ack cycle; flush_cnt=1.
- **Timeout:** WAIT_MAX=4, req held with no ack -> after 4 WAIT cycles o_state=2 and o_halt=1, enables stay 0 for 20 more cycles; reset -> RUN with counters at 0.
- **Saturation and async reset:** CNT_W=4 with 20 load-use stalls -> stall_cnt stays at 15. Dropping reset mid-WAIT between clock edges clears the outputs immediately.
